// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array input/output stages.
//   fp32_t          : one IEEE-754 single-precision element
//   FP32_ZERO       : +0.0, injected into lanes that carry no data
//   feeder_state_e  : sequencing states of the skew feeder
//   N_DEFAULT       : default number of PE rows fed by the array edge
package systolic_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_ZERO = 32'h0000_0000;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  : write one word (ignored when full and not popping)
//   pop          : discard the head word (ignored when empty)
//   rdata        : current head word, valid whenever empty == 0
//   full, empty  : occupancy flags
// Pointers carry one extra wrap bit so full and empty can be told apart
// when the address bits are equal.
module sync_fifo #(
    parameter int W     = 129,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // A push into a full FIFO is only safe when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/skew_feeder.sv
// Input stage of the systolic array. Buffers whole operand vectors and
// feeds lane i into PE row i delayed by i cycles, so element k of every
// row meets its PE on the same wavefront. After the vector tagged last,
// zeros drain the skew and done pulses once.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake
//   in_data, in_last    : vector (lane i = bits [i*DW +: DW]), job-end tag
//   out_data, out_valid : skewed lanes to PE rows; data is 0 when not valid
//   busy                : first accept until done
//   done                : one-cycle pulse when the drain completes
//   state               : current sequencing state, for observation
// Handshake: a vector transfers on a rising edge where in_valid && in_ready.
// in_ready does not depend on in_valid; it is low during reset, when the
// FIFO is full, once the last vector of a job has been accepted, and in
// FLUSH/DONE.
module skew_feeder
    import systolic_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    output logic [N*DW-1:0] out_data,
    output logic [N-1:0]    out_valid,
    output logic            busy,
    output logic            done,
    output feeder_state_e   state
);

    localparam int FW = N * DW + 1;
    localparam int CW = $clog2(N) + 1;

    feeder_state_e   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_seen_q, last_seen_d;

    logic            accept;
    logic            pop_head;
    logic            full, empty;
    logic [FW-1:0]   head;
    logic [N*DW-1:0] head_data;
    logic            head_last;

    assign in_ready = rst && !full && !last_seen_q &&
                      (state_q == IDLE || state_q == STREAM);
    assign accept   = in_valid && in_ready;

    // Stage 0 takes the head whenever one exists; in FLUSH the FIFO is
    // already empty, so the skew fills with zeros.
    assign pop_head  = !empty;
    assign head_data = head[N*DW-1:0];
    assign head_last = head[FW-1];

    sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata ({in_last, in_data}),
        .pop   (pop_head),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_seen_d = last_seen_q;
        busy        = 1'b0;
        done        = 1'b0;

        if (accept && in_last) last_seen_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) state_d = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (pop_head && head_last) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                // Stay until the last lane has shown the final vector.
                busy = 1'b1;
                if (cnt_q == CW'(N - 1)) state_d = DONE;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
                done        = 1'b1;
                last_seen_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;

    // Lane i: stage-0 register followed by i further delay registers.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] d_q [i+1];
        logic          v_q [i+1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= i; k++) begin
                    d_q[k] <= '0;
                    v_q[k] <= 1'b0;
                end
            end else begin
                d_q[0] <= pop_head ? head_data[i*DW +: DW] : DW'(FP32_ZERO);
                v_q[0] <= pop_head;
                for (int k = 1; k <= i; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign out_data[i*DW +: DW] = d_q[i];
        assign out_valid[i]         = v_q[i];
    end

endmodule

// File: tb/tb_skew_feeder.sv
module tb_skew_feeder;
    import systolic_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int VW    = N * DW;

    // ---------------- clock / reset ----------------
    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_data  = '0;
    logic          in_last  = 1'b0;
    logic [VW-1:0] out_data;
    logic [N-1:0]  out_valid;
    logic          busy;
    logic          done;
    feeder_state_e state;

    always #5 clk = ~clk;

    skew_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .state     (state)
    );

    // posedge counter; read at negedge it equals the index of the last edge
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];    // accepted vectors, in order
    int            exp_cyc[$];  // edge at which each vector was accepted
    int            done_q[$];   // edge after which done must be high
    int            rd_idx[N];
    int            done_idx = 0;
    int            errors   = 0;
    int            checks   = 0;

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [VW-1:0] v, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = v;
        in_last  = l;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, guard);
        end else begin
            exp_q.push_back(v);
            exp_cyc.push_back(cyc + 1);
            if (l) done_q.push_back(cyc + 1 + N + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [VW-1:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic drain_and_check(input string tag);
        repeat (N + 6) @(negedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("%s_lane%0d_consumed", tag, i), VW'(rd_idx[i]), VW'(exp_q.size()));
        chk({tag, "_done_count"}, VW'(done_idx), VW'(done_q.size()));
        chk({tag, "_busy_idle"}, VW'(busy), '0);
        chk({tag, "_ready_idle"}, VW'(in_ready), VW'(1));
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [VW-1:0] v;
        logic [DW-1:0] e;
        int            want_cyc;
        forever begin
            @(negedge clk);
            // Reset discards everything in flight.
            if (!rst) begin
                for (int i = 0; i < N; i++) rd_idx[i] = exp_q.size();
                done_idx = done_q.size();
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (out_valid[i]) begin
                    if (rd_idx[i] >= exp_q.size()) begin
                        errors++;
                        $display("FAIL lane%0d_extra: got beat %h at edge %0d, expected none",
                                 i, out_data[i*DW +: DW], cyc);
                    end else begin
                        v        = exp_q[rd_idx[i]];
                        e        = v[i*DW +: DW];
                        want_cyc = exp_cyc[rd_idx[i]] + 1 + i;
                        if (out_data[i*DW +: DW] !== e || cyc != want_cyc) begin
                            errors++;
                            $display("FAIL lane%0d_beat: got %h at edge %0d, expected %h at edge %0d",
                                     i, out_data[i*DW +: DW], cyc, e, want_cyc);
                        end
                        rd_idx[i]++;
                    end
                end else if (out_data[i*DW +: DW] !== '0) begin
                    errors++;
                    $display("FAIL lane%0d_idle_zero: got %h, expected 00000000", i, out_data[i*DW +: DW]);
                end
            end
            if (done) begin
                checks++;
                if (done_idx >= done_q.size()) begin
                    errors++;
                    $display("FAIL done_extra: done at edge %0d, expected none", cyc);
                end else begin
                    if (cyc != done_q[done_idx] || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL done_pulse: got edge %0d busy %0b, expected edge %0d busy 0",
                                 cyc, busy, done_q[done_idx]);
                    end
                    done_idx++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b0;
        in_valid = 1'b1;
        in_data  = {N{32'hDEAD_BEEF}};
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  VW'(in_ready),  '0);
        chk("rst_out_valid", VW'(out_valid), '0);
        chk("rst_out_data",  out_data,       '0);
        chk("rst_busy",      VW'(busy),      '0);
        chk("rst_done",      VW'(done),      '0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", VW'(in_ready), VW'(1));

        // single vector, last on the first beat
        send(vec(32'h4000_0000, 32'h4080_0000, 32'h4100_0000, 32'h4180_0000), 1'b1);
        chk("single_busy", VW'(busy), VW'(1));
        chk("single_ready_after_last", VW'(in_ready), '0);
        drain_and_check("single");

        // four back-to-back vectors
        send(vec(32'h4000_0000, 32'h4100_0000, 32'h4100_0000, 32'h4100_0000), 1'b0);
        send(vec(32'h4080_0000, 32'h4100_0000, 32'h4100_0000, 32'h4100_0000), 1'b0);
        send(vec(32'h4100_0000, 32'h4100_0000, 32'h4100_0000, 32'h4100_0000), 1'b0);
        send(vec(32'h4180_0000, 32'h4100_0000, 32'h4100_0000, 32'h4100_0000), 1'b1);
        drain_and_check("b2b");

        // DEPTH+1 vectors back-to-back, order preserved
        for (int k = 0; k <= DEPTH; k++)
            send(vec(32'h1000_0000 + k, 32'h2000_0000 + k, 32'h3000_0000 + k, 32'h4000_0000 + k),
                 k == DEPTH);
        chk("burst_ready_after_last", VW'(in_ready), '0);
        drain_and_check("burst");

        // gapped input: a bubble walks across the lanes
        send(vec(32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003), 1'b0);
        @(negedge clk);
        send(vec(32'hBBBB_0000, 32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003), 1'b1);
        drain_and_check("gap");

        // reset during FLUSH
        send(vec(32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003), 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", VW'(out_valid), '0);
        chk("midrst_out_data",  out_data,       '0);
        chk("midrst_busy",      VW'(busy),      '0);
        chk("midrst_in_ready",  VW'(in_ready),  '0);
        chk("midrst_state",     VW'(state),     VW'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(vec(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000), 1'b1);
        drain_and_check("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/skew_feeder.md
Name: skew_feeder

Overview:
- Upstream input stage of the systolic array: buffers whole operand vectors (one FP32 element per PE row) and drives them into the array's row inputs with a diagonal skew.
- Lane i is delayed i cycles relative to lane 0, so element k of every row reaches the correct PE on the same wavefront.
- After the final vector it drains the skew with FP32 zeros, so the downstream PE accumulators are unaffected, then pulses done.

Parameters:
- N, 4, number of lanes (PE rows fed); N >= 2.
- DW, 32, element width (IEEE-754 single).
- DEPTH, 4, input FIFO depth in vectors; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a vector on in_data.
- in_ready  out  1  feeder accepts in_data this cycle.
- in_data  in  N*DW  vector; lane i = bits [i*DW +: DW].
- in_last  in  1  qualifies the accepted vector as the final one of the job.
- out_data  out  N*DW  skewed lane data to PE row inputs; zero when the lane is not valid.
- out_valid  out  N  per-lane valid.
- busy  out  1  high from first accept until done.
- done  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, all skew registers 0. Outputs out_data=0, out_valid=0, busy=0, done=0, in_ready=0 while rst is low. A reset mid-job discards all buffered and in-flight data.
- Handshake: a transfer occurs when in_valid && in_ready on a rising edge. in_ready = !fifo_full && state in {IDLE, STREAM}. After in_last is accepted, in_ready stays 0 until the feeder returns to IDLE.
- Skew pipeline: stage 0 loads every cycle.
  - If the FIFO is non-empty, stage 0 pops the head and takes lane 0 of that vector with valid=1.
  - Otherwise stage 0 takes a bubble: data 0x00000000, valid=0.
  - Lane i's output register holds lane i of the vector popped i cycles earlier. Implement as per-lane delay chains of length i, registered.
- Latency: for a vector accepted into an empty FIFO at edge T:
  - popped at edge T+1;
  - lane 0 visible after edge T+1;
  - lane i visible after edge T+1+i.
  - Back-to-back vectors produce back-to-back beats on every lane.
- FSM:
  - IDLE -> STREAM on the first accept. busy=1 from that edge.
  - STREAM -> FLUSH when the vector tagged in_last is popped.
  - FLUSH: stage 0 injects zeros; count N-1 cycles, until the last lane has emitted the final vector.
  - FLUSH -> DONE when the counter expires.
  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- The tag bit is stored in the FIFO alongside the data. Accept and pop in the same cycle are legal when the FIFO is full: occupancy is unchanged, and in_ready is computed from full before the pop.
- A single-vector job with in_last on the first beat goes IDLE -> STREAM -> FLUSH normally.
- FIFO pointers are log2(DEPTH)+1 bits and wrap; full and empty are derived from the MSB and the address compare.
- No arithmetic is performed on the data; it passes bit-exact.

Decomposition:
- Shared package systolic_pkg:
  - typedef fp32_t (logic [31:0]);
  - constant FP32_ZERO = 32'h0;
  - enum feeder_state_e {IDLE, STREAM, FLUSH, DONE};
  - localparam default N.
- One sub-module: sync_fifo (DW*N+1 wide, DEPTH deep, with full/empty), reusable for the output drain stage.
- Skew chains and the FSM stay in skew_feeder.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0000, out_data=0. Release rst: in_ready=1 on the next cycle.
- Single vector {0x40000000, 0x40800000, 0x41000000, 0x41800000} with in_last=1, accepted at edge T:
  - lane 0 shows 0x40000000 after T+1; lane 3 shows 0x41800000 after T+4;
  - each lane valid for exactly one cycle;
  - done pulses at T+5;
  - busy falls with done.
- Four back-to-back vectors, lane 0 values 2.0, 4.0, 8.0, 16.0 (0x40000000..0x41800000) and lanes 1-3 constant 0x41000000, last on the 4th:
  - lane 0 emits 0x40000000, 0x40800000, 0x41000000, 0x41800000 on consecutive cycles;
  - lane 3 emits the same stream shifted 3 cycles;
  - no bubbles;
  - one done pulse.
- Backpressure: push DEPTH+1 vectors without pops possible -> in_ready=0 after DEPTH accepts; data order is preserved; no loss or duplication.
- Gapped input, in_valid toggled 1,0,1 -> a bubble propagates diagonally: out_valid pattern shows a 0 appearing on lane i at cycle offset i, and that lane's data is 0x00000000.
- Reset asserted during FLUSH -> all outputs go to 0 immediately (async); no done pulse; a subsequent job behaves as from cold reset.
